// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams activations against a registered weight ROM,
// then adds the bias and emits one ReLU-saturated output per frame of numWeight inputs.
module neuron_mac #(
  parameter int                    numWeight    = 10,
  parameter int                    addressWidth = $clog2(numWeight),
  parameter int                    dataWidth    = 16,
  parameter int                    fracBits     = 12,
  parameter logic [dataWidth-1:0]  biasValue    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_data,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data
);

  // Handshake: an activation transfers on any rising edge where in_valid && in_ready;
  // in_valid may drop between transfers, and out_valid is a one-cycle pulse with no backpressure.

  localparam int PW   = 2 * dataWidth;
  localparam int ACCW = PW + addressWidth + 1;
  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);
  localparam logic [ACCW-1:0] BIAS_SH =
    {{(ACCW-dataWidth){biasValue[dataWidth-1]}}, biasValue} << fracBits;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t                   r_state;
  logic [addressWidth-1:0]  r_idx;
  logic [dataWidth-1:0]     r_in_d1;
  logic                     r_v1;
  logic                     r_last1;
  logic signed [PW-1:0]     r_prod;
  logic                     r_v2;
  logic                     r_last2;
  logic                     r_last3;
  logic signed [ACCW-1:0]   r_acc;
  logic                     r_out_valid;
  logic [dataWidth-1:0]     r_out_data;

  logic                     w_accept;
  logic                     w_is_last;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACCW-1:0]   w_sum;
  logic signed [ACCW-1:0]   w_res;
  logic [dataWidth-1:0]     w_out;

  always_comb begin
    w_accept  = in_valid && (r_state == RUN);
    w_is_last = (r_idx == LAST_IDX);
    w_prod    = $signed(r_in_d1) * $signed(w_data);
    w_sum     = r_acc + $signed(BIAS_SH);
    w_res     = w_sum >>> fracBits;
    // ReLU with clamp to the largest positive Q value
    if (w_res[ACCW-1])
      w_out = '0;
    else if (|w_res[ACCW-2:dataWidth-1])
      w_out = {1'b0, {(dataWidth-1){1'b1}}};
    else
      w_out = w_res[dataWidth-1:0];
  end

  assign in_ready  = (r_state == RUN);
  assign w_ren     = w_accept;
  assign w_radd    = r_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_idx       <= '0;
      r_in_d1     <= '0;
      r_v1        <= 1'b0;
      r_last1     <= 1'b0;
      r_prod      <= '0;
      r_v2        <= 1'b0;
      r_last2     <= 1'b0;
      r_last3     <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_v1        <= w_accept;
      r_last1     <= w_accept && w_is_last;
      r_prod      <= w_prod;
      r_v2        <= r_v1;
      r_last2     <= r_last1;
      r_last3     <= r_last2;
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_in_d1 <= in_data;
        r_idx   <= w_is_last ? '0 : r_idx + addressWidth'(1);
        if (w_is_last) r_state <= DRAIN;
      end
      // The last product lands in acc one cycle before r_last3, so the sum is complete here
      if (r_last3) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_out;
        r_acc       <= '0;
        r_state     <= RUN;
      end else if (r_v2) begin
        r_acc <= r_acc + {{(ACCW-PW){r_prod[PW-1]}}, r_prod};
      end
    end
  end

endmodule
